// File: rtl/uivtc_gen.sv
// -----------------------------------------------------------------------------
// uivtc_gen -- video timing generator
//
// Produces hsync / vsync / data-enable timing plus active-area pixel
// coordinates for a raster described by the porch/sync/active parameters.
// The line starts with the sync pulse, then back porch, active area and
// front porch; the frame is laid out the same way in lines.
//
// A small IDLE / RUN / DRAIN state machine ensures that only whole frames
// are ever emitted: dropping vtc_en_i lets the current frame finish, and
// raising it again before the frame ends resumes with no timing gap.
//
// Ports
//   vtc_clk_i   in   1   pixel clock, all logic on its rising edge
//   vtc_rstn_i  in   1   asynchronous active-low reset
//   vtc_en_i    in   1   run request, sampled every clock
//   vtc_vs_o    out  1   vertical sync, active level VS_POL
//   vtc_hs_o    out  1   horizontal sync, active level HS_POL
//   vtc_de_o    out  1   data enable, active high
//   vtc_x_o     out  12  active pixel column (0 when de is low)
//   vtc_y_o     out  12  active line row (0 when de is low)
//   vtc_sof_o   out  1   one-cycle start-of-frame pulse
//   vtc_fcnt_o  out  16  completed-frame counter
//
// Build option
//   VTC_FCNT_EN  when defined, vtc_fcnt_o counts completed frames (16-bit
//                wrap); when undefined it is tied to 0 and no counter exists.
//
// All outputs are registered: the outputs of cycle t+1 describe the
// counter position of cycle t. H_TOTAL and V_TOTAL must not exceed 4095.
// -----------------------------------------------------------------------------
module uivtc_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        vtc_clk_i,
  input  logic        vtc_rstn_i,
  input  logic        vtc_en_i,
  output logic        vtc_vs_o,
  output logic        vtc_hs_o,
  output logic        vtc_de_o,
  output logic [11:0] vtc_x_o,
  output logic [11:0] vtc_y_o,
  output logic        vtc_sof_o,
  output logic [15:0] vtc_fcnt_o
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
  localparam logic [11:0] H_DE_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_DE_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_DE_START = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_DE_END   = 12'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [11:0] h_cnt_reg, h_cnt_next;
  logic [11:0] v_cnt_reg, v_cnt_next;

  logic        vs_reg, hs_reg, de_reg, sof_reg;
  logic [11:0] x_reg, y_reg;

  logic        active;
  logic        h_last, v_last, frame_last;
  logic        hs_in, vs_in, de_in, sof_in;
  logic [11:0] x_in, y_in;

  // Counters only hold a meaningful raster position outside IDLE.
  assign active     = (state_reg != ST_IDLE);
  assign h_last     = (h_cnt_reg == H_LAST);
  assign v_last     = (v_cnt_reg == V_LAST);
  assign frame_last = active && h_last && v_last;

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (vtc_en_i) state_next = ST_RUN;
      end
      ST_RUN: begin
        // A stop request on the very last pixel has nothing left to drain.
        if (!vtc_en_i) state_next = frame_last ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        // A run request always wins, including on the last pixel, so the
        // next frame follows without a gap.
        if (vtc_en_i)        state_next = ST_RUN;
        else if (frame_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // The raster wraps to (0,0) after the last pixel, which is also the
    // position IDLE holds, so leaving DRAIN needs no special handling.
    if (!active) begin
      h_cnt_next = '0;
      v_cnt_next = '0;
    end else if (h_last) begin
      h_cnt_next = '0;
      v_cnt_next = v_last ? 12'd0 : v_cnt_reg + 12'd1;
    end else begin
      h_cnt_next = h_cnt_reg + 12'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Timing decode of the current position (registered below)
  // ---------------------------------------------------------------------------
  always_comb begin
    hs_in  = active && (h_cnt_reg < H_SYNC_END);
    // Depends on v_cnt only, which changes solely when h_cnt wraps to 0.
    vs_in  = active && (v_cnt_reg < V_SYNC_END);
    de_in  = active &&
             (h_cnt_reg >= H_DE_START) && (h_cnt_reg < H_DE_END) &&
             (v_cnt_reg >= V_DE_START) && (v_cnt_reg < V_DE_END);
    x_in   = de_in ? (h_cnt_reg - H_DE_START) : 12'd0;
    y_in   = de_in ? (v_cnt_reg - V_DE_START) : 12'd0;
    sof_in = (state_reg == ST_RUN) && (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
  end

  // ---------------------------------------------------------------------------
  // State, counters and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
    if (!vtc_rstn_i) begin
      state_reg <= ST_IDLE;
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
      vs_reg    <= ~VS_POL;
      hs_reg    <= ~HS_POL;
      de_reg    <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      sof_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
      vs_reg    <= vs_in ? VS_POL : ~VS_POL;
      hs_reg    <= hs_in ? HS_POL : ~HS_POL;
      de_reg    <= de_in;
      x_reg     <= x_in;
      y_reg     <= y_in;
      sof_reg   <= sof_in;
    end
  end

  assign vtc_vs_o  = vs_reg;
  assign vtc_hs_o  = hs_reg;
  assign vtc_de_o  = de_reg;
  assign vtc_x_o   = x_reg;
  assign vtc_y_o   = y_reg;
  assign vtc_sof_o = sof_reg;

`ifdef VTC_FCNT_EN
  logic [15:0] fcnt_reg;

  // Counts on the last pixel of a frame, so the new value is visible in the
  // cycle after that pixel (16-bit natural wrap).
  always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
    if (!vtc_rstn_i) begin
      fcnt_reg <= '0;
    end else if (frame_last) begin
      fcnt_reg <= fcnt_reg + 16'd1;
    end
  end

  assign vtc_fcnt_o = fcnt_reg;
`else
  assign vtc_fcnt_o = 16'd0;
`endif

endmodule

// File: doc/uivtc_gen.md
UIVTC_GEN -- requirements
Module: uivtc_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE (1920, active pixels per line), H_FP (88, front porch), H_SYNC (44, hsync width), H_BP (148, back porch), V_ACTIVE (1080, active lines), V_FP (4), V_SYNC (5), V_BP (36), HS_POL (1, hsync active level), VS_POL (1, vsync active level).
REQ-002 SHALL have one clock and an asynchronous active-low reset: vtc_clk_i  input  1  pixel clock, all logic on its rising edge.
REQ-003 SHALL have port vtc_rstn_i  input  1  asynchronous active-low reset.
REQ-004 SHALL have port vtc_en_i  input  1  run request, sampled on every clock.
REQ-005 SHALL have port vtc_vs_o  output  1  vertical sync, level set by VS_POL.
REQ-006 SHALL have port vtc_hs_o  output  1  horizontal sync, level set by HS_POL.
REQ-007 SHALL have port vtc_de_o  output  1  data enable, active high.
REQ-008 SHALL have port vtc_x_o  output  12  active pixel column, 0 when de is low.
REQ-009 SHALL have port vtc_y_o  output  12  active line row, 0 when de is low.
REQ-010 SHALL have port vtc_sof_o  output  1  one-cycle start-of-frame pulse.
REQ-011 SHALL have port vtc_fcnt_o  output  16  completed-frame counter (see Configuration).

Function
REQ-012 SHALL have H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP; both SHALL be at most 4095.
REQ-013 SHALL keep 12-bit h_cnt counting 0..H_TOTAL-1, wrapping to 0; v_cnt SHALL increment when h_cnt wraps and SHALL wrap from V_TOTAL-1 to 0.
REQ-014 SHALL be in sync when h_cnt < H_SYNC (horizontal) and when v_cnt < V_SYNC (vertical); vsync SHALL change on h_cnt = 0 only.
REQ-015 SHALL assert de when h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
REQ-016 SHALL set x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP) while de is high.
REQ-017 SHALL register all outputs; outputs in cycle t+1 SHALL reflect the counters of cycle t (1-cycle latency).
REQ-018 SHALL assert sof for the output cycle corresponding to h_cnt=0, v_cnt=0 while in RUN.
REQ-019 SHALL have a state machine with states IDLE, RUN, DRAIN; reset state SHALL be IDLE.
REQ-020 SHALL hold counters at 0 in IDLE and drive sync and de inactive; on vtc_en_i=1 it SHALL move to RUN, and the first RUN cycle SHALL have h_cnt=0, v_cnt=0.
REQ-021 SHALL move from RUN to DRAIN when vtc_en_i=0; the frame SHALL continue unchanged.
REQ-022 SHALL move from DRAIN to IDLE at h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, which means no partial frame is ever emitted.
REQ-023 SHALL return from DRAIN to RUN with no timing discontinuity if vtc_en_i=1 during DRAIN.
REQ-024 SHALL, when vtc_en_i=1 at the last pixel of a frame in DRAIN, stay running (RUN wins) and start the next frame seamlessly.

Reset
REQ-025 SHALL, while vtc_rstn_i=0, immediately force: state IDLE; h_cnt and v_cnt 0; vs = ~VS_POL; hs = ~HS_POL; de, x, y, sof 0; fcnt 0.
REQ-026 SHALL discard the frame on reset mid-frame; after release, it SHALL restart from IDLE and need vtc_en_i=1.

Configuration
REQ-027 SHALL use macro VTC_FCNT_EN: when defined, vtc_fcnt_o SHALL increment by 1 (wrapping at 16 bits) on the cycle after each completed frame (last pixel of frame in RUN or DRAIN).
REQ-028 SHALL, when VTC_FCNT_EN is undefined, drive vtc_fcnt_o to constant 0 with no counter logic; the port list SHALL be identical in both builds.

Verification
REQ-029 SHALL cover the small frame H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (H_TOTAL=14, V_TOTAL=7), en=1 -> per line hs high 2 cycles then low 12 cycles; per line de high 8 cycles starting 4 cycles after the hs rising edge; 4 de lines per 7-line frame; sof period 98 cycles.
REQ-030 SHALL cover the same setup observing x/y -> x runs 0..7 on each de line; y runs 0..3; x=y=0 outside de.
REQ-031 SHALL cover deasserting en at h_cnt=5, v_cnt=3 -> the frame completes to h_cnt=13, v_cnt=6, then sync and de stay inactive and no further sof occurs.
REQ-032 SHALL cover deasserting en for 10 cycles mid-frame and then reasserting it -> hs/de/sof periods unchanged (14/98 cycles) with no gap.
REQ-033 SHALL cover pulsing the reset low for 1 cycle during active video -> all outputs take reset values asynchronously; with en held high, the first sof follows 2 cycles after reset release.
REQ-034 SHALL cover VTC_FCNT_EN defined, 3 full frames -> fcnt = 3; VTC_FCNT_EN undefined -> fcnt = 0 throughout; HS_POL=0 build -> hs idles high and pulses low for 2 cycles.
